// File: rtl/dma_read_src_fsm.sv
// DMA read-side engine: one descriptor at a time, single-outstanding AXI read bursts into the data FIFO.
// Optional perf counters built only when DMA_RD_PERF_CNTR_EN is defined.
module dma_read_src_fsm #(
    parameter int DATA_W   = 512,
    parameter int ADDR_W   = 64,
    parameter int LENGTH_W = 24,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                desc_valid,
    input  logic [ADDR_W-1:0]   desc_src_addr,
    input  logic [LENGTH_W-1:0] desc_length,
    output logic                desc_ready,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    output logic                fifo_wr_en,
    output logic [DATA_W-1:0]   fifo_wr_data,
    input  logic                fifo_almost_full,
    input  logic                clear_error,
    output logic                rd_fsm_done,
    output logic                busy,
    output logic                rd_rsp_err,
    output logic [PERF_W-1:0]   rd_src_clk_cnt,
    output logic [PERF_W-1:0]   rd_src_valid_cnt
);
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int NB_W = LENGTH_W - 7;
    localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(256 * BEAT_BYTES);

    typedef enum logic [3:0] {
        S_IDLE       = 4'b0001,
        S_ADDR_SETUP = 4'b0010,
        S_RD_DATA    = 4'b0100,
        S_ERROR      = 4'b1000
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          last_len_q, last_len_d;
    logic [NB_W-1:0]     num_bursts_q, num_bursts_d;
    logic [NB_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic                done_q, done_d;
    logic [LENGTH_W-1:0] len_m1;
    logic                final_burst;
    logic                unused_rresp0;

    assign unused_rresp0 = rresp[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            last_len_q   <= '0;
            num_bursts_q <= '0;
            burst_cnt_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_len_q   <= last_len_d;
            num_bursts_q <= num_bursts_d;
            burst_cnt_q  <= burst_cnt_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_len_d   = last_len_q;
        num_bursts_d = num_bursts_q;
        burst_cnt_d  = burst_cnt_q;
        done_d       = 1'b0;
        desc_ready   = 1'b0;
        arvalid      = 1'b0;
        arlen        = 8'd0;
        rready       = 1'b0;
        fifo_wr_en   = 1'b0;
        rd_rsp_err   = 1'b0;
        len_m1       = desc_length - LENGTH_W'(1);
        final_burst  = (burst_cnt_q + NB_W'(1)) == num_bursts_q;
        case (state_q)
            S_IDLE: begin
                if (desc_valid) begin
                    desc_ready   = 1'b1;
                    addr_d       = desc_src_addr;
                    last_len_d   = len_m1[7:0];
                    num_bursts_d = {1'b0, len_m1[LENGTH_W-1:8]} + NB_W'(1);
                    burst_cnt_d  = '0;
                    if (desc_length == '0) done_d = 1'b1;
                    else                   state_d = S_ADDR_SETUP;
                end
            end
            S_ADDR_SETUP: begin
                arvalid = 1'b1;
                arlen   = final_burst ? last_len_q : 8'hFF;
                if (arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready = !fifo_almost_full;
                if (rvalid && rready) begin
                    // Errored beats never reach the FIFO; the rest of the burst drains in ERROR.
                    if (rresp[1]) begin
                        state_d = S_ERROR;
                    end else begin
                        fifo_wr_en = 1'b1;
                        if (rlast) begin
                            burst_cnt_d = burst_cnt_q + NB_W'(1);
                            if (final_burst) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                addr_d  = addr_q + BURST_STRIDE;
                                state_d = S_ADDR_SETUP;
                            end
                        end
                    end
                end
            end
            S_ERROR: begin
                rready     = 1'b1;
                rd_rsp_err = 1'b1;
                if (clear_error) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign araddr       = addr_q;
    assign arsize       = 3'($clog2(BEAT_BYTES));
    assign arburst      = 2'b01;
    assign fifo_wr_data = rdata;
    assign rd_fsm_done  = done_q;
    assign busy         = (state_q != S_IDLE);

`ifdef DMA_RD_PERF_CNTR_EN
    logic [PERF_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [PERF_W-1:0] valid_cnt_q, valid_cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_cnt_q   <= '0;
            valid_cnt_q <= '0;
        end else begin
            clk_cnt_q   <= clk_cnt_d;
            valid_cnt_q <= valid_cnt_d;
        end
    end

    // Both counters saturate rather than wrap.
    always_comb begin
        clk_cnt_d   = clk_cnt_q;
        valid_cnt_d = valid_cnt_q;
        if (desc_ready) begin
            clk_cnt_d   = '0;
            valid_cnt_d = '0;
        end else begin
            if ((state_q == S_ADDR_SETUP || state_q == S_RD_DATA) && clk_cnt_q != '1)
                clk_cnt_d = clk_cnt_q + PERF_W'(1);
            if (fifo_wr_en && valid_cnt_q != '1)
                valid_cnt_d = valid_cnt_q + PERF_W'(1);
        end
    end

    assign rd_src_clk_cnt   = clk_cnt_q;
    assign rd_src_valid_cnt = valid_cnt_q;
`else
    assign rd_src_clk_cnt   = '0;
    assign rd_src_valid_cnt = '0;
`endif

endmodule
